// File: rtl/conv_issue_sequencer.sv
// Issue sequencer for a KSIZE x KSIZE convolution: scans kernel taps per output pixel,
// feeds a fixed-latency MAC pipeline and tracks when each accumulated pixel exits.
module conv_issue_sequencer #(
  parameter int KSIZE   = 3,
  parameter int LATENCY = 7,
  parameter int DIM_W   = 8
) (
  input  logic             clk,
  input  logic             aclr,
  input  logic             start,
  input  logic [DIM_W-1:0] cfg_width,
  input  logic [DIM_W-1:0] cfg_height,
  input  logic             hold,
  output logic             issue_valid,
  output logic [DIM_W-1:0] tap_row,
  output logic [DIM_W-1:0] tap_col,
  output logic [DIM_W-1:0] out_row,
  output logic [DIM_W-1:0] out_col,
  output logic             first_tap,
  output logic             last_tap,
  output logic             result_valid,
  output logic [DIM_W-1:0] result_row,
  output logic [DIM_W-1:0] result_col,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [DIM_W-1:0] K_DIM  = DIM_W'(KSIZE);
  localparam logic [DIM_W-1:0] K_LAST = DIM_W'(KSIZE - 1);
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           state_q, state_d;
  logic [DIM_W-1:0] cfg_w_q, cfg_w_d, cfg_h_q, cfg_h_d;
  logic             cfg_err_q, cfg_err_d;
  logic [DIM_W-1:0] tr_q, tr_d, tc_q, tc_d, or_q, or_d, oc_q, oc_d;
  logic [CNT_W-1:0] drain_q, drain_d;
  logic             pv_q [LATENCY];
  logic             pv_d [LATENCY];
  logic [DIM_W-1:0] pr_q [LATENCY];
  logic [DIM_W-1:0] pr_d [LATENCY];
  logic [DIM_W-1:0] pc_q [LATENCY];
  logic [DIM_W-1:0] pc_d [LATENCY];

  logic [DIM_W-1:0] oc_lim, or_lim;
  logic             tap_end;

  assign oc_lim  = cfg_w_q - K_DIM;
  assign or_lim  = cfg_h_q - K_DIM;
  assign tap_end = (tr_q == K_LAST) && (tc_q == K_LAST);

  assign issue_valid  = (state_q == RUN) && !hold;
  assign tap_row      = tr_q;
  assign tap_col      = tc_q;
  assign out_row      = or_q;
  assign out_col      = oc_q;
  assign first_tap    = issue_valid && (tr_q == '0) && (tc_q == '0);
  assign last_tap     = issue_valid && tap_end;
  assign result_valid = pv_q[LATENCY-1];
  assign result_row   = pr_q[LATENCY-1];
  assign result_col   = pc_q[LATENCY-1];
  assign busy         = (state_q != IDLE);
  assign done         = (state_q == DONE);
  assign err          = (state_q == DONE) && cfg_err_q;

  always_comb begin
    state_d   = state_q;
    cfg_w_d   = cfg_w_q;
    cfg_h_d   = cfg_h_q;
    cfg_err_d = cfg_err_q;
    tr_d      = tr_q;
    tc_d      = tc_q;
    or_d      = or_q;
    oc_d      = oc_q;
    drain_d   = drain_q;
    case (state_q)
      IDLE: if (start) begin
        cfg_w_d   = cfg_width;
        cfg_h_d   = cfg_height;
        tr_d      = '0;
        tc_d      = '0;
        or_d      = '0;
        oc_d      = '0;
        cfg_err_d = (cfg_width < K_DIM) || (cfg_height < K_DIM);
        state_d   = cfg_err_d ? DONE : RUN;
      end
      RUN: if (!hold) begin
        // tap_col fastest, out_row slowest; all wrap to 0 after the frame's final tap
        if (tc_q != K_LAST) tc_d = tc_q + DIM_W'(1);
        else begin
          tc_d = '0;
          if (tr_q != K_LAST) tr_d = tr_q + DIM_W'(1);
          else begin
            tr_d = '0;
            if (oc_q != oc_lim) oc_d = oc_q + DIM_W'(1);
            else begin
              oc_d = '0;
              if (or_q != or_lim) or_d = or_q + DIM_W'(1);
              else begin
                or_d    = '0;
                drain_d = DRAIN_LOAD;
                state_d = DRAIN;
              end
            end
          end
        end
      end
      DRAIN: begin
        if (drain_q == '0) state_d = DONE;
        else drain_d = drain_q - CNT_W'(1);
      end
      DONE: begin
        cfg_err_d = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    for (int i = 0; i < LATENCY; i++) begin
      pv_d[i] = 1'b0;
      pr_d[i] = '0;
      pc_d[i] = '0;
    end
    pv_d[0] = last_tap;
    pr_d[0] = or_q;
    pc_d[0] = oc_q;
    for (int i = 1; i < LATENCY; i++) begin
      pv_d[i] = pv_q[i-1];
      pr_d[i] = pr_q[i-1];
      pc_d[i] = pc_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (aclr) begin
      state_q   <= IDLE;
      cfg_w_q   <= '0;
      cfg_h_q   <= '0;
      cfg_err_q <= 1'b0;
      tr_q      <= '0;
      tc_q      <= '0;
      or_q      <= '0;
      oc_q      <= '0;
      drain_q   <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        pv_q[i] <= 1'b0;
        pr_q[i] <= '0;
        pc_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      cfg_w_q   <= cfg_w_d;
      cfg_h_q   <= cfg_h_d;
      cfg_err_q <= cfg_err_d;
      tr_q      <= tr_d;
      tc_q      <= tc_d;
      or_q      <= or_d;
      oc_q      <= oc_d;
      drain_q   <= drain_d;
      for (int i = 0; i < LATENCY; i++) begin
        pv_q[i] <= pv_d[i];
        pr_q[i] <= pr_d[i];
        pc_q[i] <= pc_d[i];
      end
    end
  end

endmodule

// File: tb/tb_conv_issue_sequencer.sv
// Scoreboard bench for conv_issue_sequencer: directed frames push expected issues,
// results and done pulses; a negedge monitor pops and compares against DUT outputs.
module tb_conv_issue_sequencer;

  localparam int K = 3;
  localparam int LAT = 7;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic aclr, start, hold;
  logic [DW-1:0] cfg_width, cfg_height;
  logic issue_valid, first_tap, last_tap, result_valid, busy, done, err;
  logic [DW-1:0] tap_row, tap_col, out_row, out_col, result_row, result_col;

  conv_issue_sequencer #(.KSIZE(K), .LATENCY(LAT), .DIM_W(DW)) dut (
    .clk(clk), .aclr(aclr), .start(start), .cfg_width(cfg_width), .cfg_height(cfg_height),
    .hold(hold), .issue_valid(issue_valid), .tap_row(tap_row), .tap_col(tap_col),
    .out_row(out_row), .out_col(out_col), .first_tap(first_tap), .last_tap(last_tap),
    .result_valid(result_valid), .result_row(result_row), .result_col(result_col),
    .busy(busy), .done(done), .err(err));

  always #5 clk = ~clk;

  typedef struct {int cyc; int tr; int tc; int orow; int ocol; int first; int last;} iss_t;
  typedef struct {int cyc; int row; int col;} res_t;
  typedef struct {int cyc; int err;} dn_t;

  iss_t iq[$];
  res_t rq[$];
  dn_t  dq[$];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int t0 = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc - t0);
    end
  endtask

  always @(negedge clk) begin
    int rel;
    rel = cyc - t0;
    if (issue_valid) begin
      if (iq.size() == 0) chk("unexpected_issue", 1, 0);
      else begin
        iss_t e;
        e = iq.pop_front();
        chk("issue_cycle", rel, e.cyc);
        chk("tap_row", int'(tap_row), e.tr);
        chk("tap_col", int'(tap_col), e.tc);
        chk("out_row", int'(out_row), e.orow);
        chk("out_col", int'(out_col), e.ocol);
        chk("first_tap", int'(first_tap), e.first);
        chk("last_tap", int'(last_tap), e.last);
      end
    end
    if (result_valid) begin
      if (rq.size() == 0) chk("unexpected_result", 1, 0);
      else begin
        res_t r;
        r = rq.pop_front();
        chk("result_cycle", rel, r.cyc);
        chk("result_row", int'(result_row), r.row);
        chk("result_col", int'(result_col), r.col);
      end
    end
    if (done) begin
      if (dq.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        dn_t d;
        d = dq.pop_front();
        chk("done_cycle", rel, d.cyc);
        chk("err", int'(err), d.err);
      end
    end else if (err) chk("err_without_done", 1, 0);
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_outputs"}, int'({issue_valid, first_tap, last_tap, result_valid, busy, done, err}), 0);
    chk({tag, "_coords"}, int'(tap_row | tap_col | out_row | out_col | result_row | result_col), 0);
  endtask

  // rst_cyc < 0: full frame. done_cyc: hand-computed done pulse cycle (-1 when reset aborts).
  task automatic run_frame(input int w, input int h, input int hlo, input int hhi,
                           input int done_cyc, input int err_exp, input int rst_cyc,
                           input int s1, input int s2);
    int c, last_c, bound;
    @(posedge clk); #1;
    t0 = cyc;
    start = 1'b1; hold = 1'b0;
    cfg_width = DW'(w); cfg_height = DW'(h);
    c = 1;
    if (w >= K && h >= K) begin
      for (int orow = 0; orow <= h - K; orow++)
        for (int ocol = 0; ocol <= w - K; ocol++)
          for (int tr = 0; tr < K; tr++)
            for (int tc = 0; tc < K; tc++) begin
              while (c >= hlo && c <= hhi) c++;
              last_c = ((tr == K-1) && (tc == K-1)) ? 1 : 0;
              if (rst_cyc < 0 || c <= rst_cyc) begin
                iq.push_back('{c, tr, tc, orow, ocol, (tr == 0 && tc == 0) ? 1 : 0, last_c});
                if (last_c == 1 && rst_cyc < 0) rq.push_back('{c + LAT, orow, ocol});
              end
              c++;
            end
    end
    if (done_cyc >= 0) dq.push_back('{done_cyc, err_exp});
    bound = (rst_cyc >= 0) ? rst_cyc + 1 : done_cyc + 2;
    for (int i = 1; i <= bound; i++) begin
      @(posedge clk); #1;
      start = (i == s1 || i == s2);
      hold  = (i >= hlo && i <= hhi);
      aclr  = (i == rst_cyc);
      if (i == 1) begin
        @(negedge clk);
        chk("busy_cycle1", int'(busy), 1);
      end
    end
    start = 1'b0; hold = 1'b0; aclr = 1'b0;
    @(negedge clk);
    if (rst_cyc >= 0) chk_all_zero("after_reset");
    else chk("busy_end", int'(busy), 0);
    repeat (LAT + 2) @(posedge clk);
    @(negedge clk);
    chk("iq_left", iq.size(), 0);
    chk("rq_left", rq.size(), 0);
    chk("dq_left", dq.size(), 0);
    iq.delete(); rq.delete(); dq.delete();
  endtask

  initial begin
    aclr = 1'b1; start = 1'b1; hold = 1'b1;
    cfg_width = 8'd5; cfg_height = 8'd5;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #1;
    aclr = 1'b0; start = 1'b0; hold = 1'b0;
    repeat (2) @(posedge clk);
    run_frame(3, 3, -1, -1, 17, 0, -1, -1, -1);
    run_frame(4, 3, -1, -1, 26, 0, -1, -1, -1);
    run_frame(3, 3, 4, 6, 20, 0, -1, -1, -1);
    run_frame(2, 5, -1, -1, 1, 1, -1, -1, -1);
    run_frame(3, 3, -1, -1, -1, 0, 9, -1, -1);
    run_frame(3, 3, -1, -1, 17, 0, -1, -1, -1);
    run_frame(3, 3, -1, -1, 17, 0, -1, 3, 17);
    run_frame(5, 4, 10, 12, 65, 0, -1, -1, -1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
